dispense_sequencer: RTL and testbench

//  Parametrised N-channel pigment dispense controller, next generation of the 3-motor load FSM.

---
 rtl/dispense_pkg.sv | 36 +++
 rtl/dispense_sequencer_if.sv | 29 ++
 rtl/dispense_sequencer_chan_watchdog.sv | 34 +++
 rtl/dispense_sequencer.sv | 124 ++++++++++++
 tb/tb_dispense_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dispense_pkg.sv
// Shared types and helpers for the pigment dispense sequencer.
// Holds the FSM state encoding and the channel-priority search functions.
package dispense_pkg;

    // Widest channel mask the search helpers accept; callers zero-extend.
    localparam int MAX_CH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        LOAD  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Index of the highest set bit in mask, or -1 when mask is empty.
    function automatic int highest_set(input logic [MAX_CH-1:0] mask);
        int r;
        r = -1;
        for (int i = 0; i < MAX_CH; i++) begin
            if (mask[i]) r = i;
        end
        return r;
    endfunction

    // Index of the highest set bit strictly below idx, or -1 if there is none.
    function automatic int next_lower_set(input logic [MAX_CH-1:0] mask, input int idx);
        int r;
        r = -1;
        for (int i = 0; i < MAX_CH; i++) begin
            if ((i < idx) && mask[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/dispense_sequencer_if.sv
// Operator / colour-capture / motor-driver signal bundle for dispense_sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface dispense_sequencer_if #(
    parameter int N_CH = 3
);
    localparam int IDX_W = $clog2(N_CH) | 1;

    logic             rgb_full;
    logic             enter;
    logic             abort;
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  flags;
    logic [N_CH-1:0]  motores;
    logic [IDX_W-1:0] ch_idx;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output rgb_full, enter, abort, ch_en, flags,
        input  motores, ch_idx, busy, done, error
    );

    modport slave (
        input  rgb_full, enter, abort, ch_en, flags,
        output motores, ch_idx, busy, done, error
    );

endinterface

// File: rtl/dispense_sequencer_chan_watchdog.sv
// Per-channel watchdog: counts enabled cycles and flags expiry when the
// count reaches TIMEOUT_CYC-1. clr has priority over counting.
module chan_watchdog #(
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

    assign expired = (wdog_q == TIMEOUT_W'(TIMEOUT_CYC - 1));

    // Next count: clear on channel change or outside LOAD, otherwise count up.
    always_comb begin
        wdog_d = wdog_q;
        if (clr) begin
            wdog_d = '0;
        end else if (en) begin
            wdog_d = wdog_q + TIMEOUT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end

endmodule

// File: rtl/dispense_sequencer.sv
// N-channel pigment dispense sequencer. Drives one motor at a time, highest
// enabled channel first, advancing when that channel's flag is seen.
// Optional feature macro: WATCHDOG_EN adds a per-channel timeout and FAULT state.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    dispense_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(N_CH) | 1;

    state_t           state_q, state_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
    logic             advance;
    logic             wd_expired;
    logic [MAX_CH-1:0] ch_en_ext, mask_ext, flags_ext;
    int               hi_idx, lo_idx;

    // Zero-extend the channel vectors to the width the search helpers expect.
    always_comb begin
        ch_en_ext = '0;
        mask_ext  = '0;
        flags_ext = '0;
        ch_en_ext[N_CH-1:0] = bus.ch_en;
        mask_ext[N_CH-1:0]  = mask_q;
        flags_ext[N_CH-1:0] = bus.flags;
    end

    // Next-state logic: start, per-channel advance, abort and fault handling.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ch_idx_d = ch_idx_q;
        advance  = 1'b0;
        hi_idx   = highest_set(ch_en_ext);
        lo_idx   = next_lower_set(mask_ext, int'(ch_idx_q));
        case (state_q)
            IDLE: begin
                if (bus.rgb_full) state_d = ARMED;
            end
            ARMED: begin
                if (!bus.rgb_full) begin
                    state_d = IDLE;
                end else if (bus.enter) begin
                    mask_d = bus.ch_en;
                    if (hi_idx < 0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOAD;
                        ch_idx_d = IDX_W'(hi_idx);
                    end
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (flags_ext[ch_idx_q]) begin
                    advance = 1'b1;
                    if (lo_idx < 0) state_d = DONE;
                    else            ch_idx_d = IDX_W'(lo_idx);
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (bus.enter || bus.abort) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured mask and active channel registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            ch_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ch_idx_q <= ch_idx_d;
        end
    end

    assign bus.motores = (state_q == LOAD) ? (N_CH'(1) << ch_idx_q) : '0;
    assign bus.ch_idx  = ch_idx_q;
    assign bus.busy    = (state_q == LOAD);
    assign bus.done    = (state_q == DONE);

`ifdef WATCHDOG_EN
    logic wd_clr, wd_en;

    assign wd_en     = (state_q == LOAD);
    assign wd_clr    = (state_q != LOAD) || advance;
    assign bus.error = (state_q == FAULT);

    chan_watchdog #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
    assign bus.error  = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer: a 3-channel and a 5-channel instance,
// a per-cycle vector table plus hand sequences for reset and watchdog corners.
module tb_dispense_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dispense_sequencer_if #(.N_CH(3)) bus3 ();
    dispense_sequencer_if #(.N_CH(5)) bus5 ();

    dispense_sequencer #(.N_CH(3), .TIMEOUT_W(16), .TIMEOUT_CYC(8)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    dispense_sequencer #(.N_CH(5), .TIMEOUT_W(16), .TIMEOUT_CYC(8)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    typedef struct {
        string      name;
        bit         sel5;
        logic       rgb;
        logic       ent;
        logic       abt;
        logic [4:0] chen;
        logic [4:0] flg;
        logic [4:0] exp_mot;
        int         exp_idx;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void addVec(input string name, input bit sel5,
                                   input logic rgb, input logic ent, input logic abt,
                                   input logic [4:0] chen, input logic [4:0] flg,
                                   input logic [4:0] exp_mot, input int exp_idx,
                                   input logic exp_busy, input logic exp_done, input logic exp_err);
        vec_t v;
        v.name = name; v.sel5 = sel5; v.rgb = rgb; v.ent = ent; v.abt = abt;
        v.chen = chen; v.flg = flg; v.exp_mot = exp_mot; v.exp_idx = exp_idx;
        v.exp_busy = exp_busy; v.exp_done = exp_done; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel5, input logic rgb, input logic ent, input logic abt,
                                 input logic [4:0] chen, input logic [4:0] flg);
        if (sel5) begin
            bus5.rgb_full = rgb;  bus5.enter = ent;  bus5.abort = abt;
            bus5.ch_en    = chen; bus5.flags = flg;
            bus3.rgb_full = 1'b0; bus3.enter = 1'b0; bus3.abort = 1'b0;
            bus3.ch_en    = '0;   bus3.flags = '0;
        end else begin
            bus3.rgb_full = rgb;  bus3.enter = ent;  bus3.abort = abt;
            bus3.ch_en    = chen[2:0]; bus3.flags = flg[2:0];
            bus5.rgb_full = 1'b0; bus5.enter = 1'b0; bus5.abort = 1'b0;
            bus5.ch_en    = '0;   bus5.flags = '0;
        end
    endtask

    task automatic checkOutput(input string name, input bit sel5, input logic [4:0] exp_mot,
                               input int exp_idx, input logic exp_busy, input logic exp_done,
                               input logic exp_err);
        logic [4:0] gm;
        int         gi;
        logic       gb, gd, ge;
        if (sel5) begin
            gm = bus5.motores; gi = int'(bus5.ch_idx);
            gb = bus5.busy; gd = bus5.done; ge = bus5.error;
        end else begin
            gm = {2'b00, bus3.motores}; gi = int'(bus3.ch_idx);
            gb = bus3.busy; gd = bus3.done; ge = bus3.error;
        end
        n_total++;
        if ({gm, gi, gb, gd, ge} === {exp_mot, exp_idx, exp_busy, exp_done, exp_err}) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got mot=%b idx=%0d busy=%b done=%b err=%b, want mot=%b idx=%0d busy=%b done=%b err=%b",
                     name, gm, gi, gb, gd, ge, exp_mot, exp_idx, exp_busy, exp_done, exp_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 5'b0);
        step();
        step();
        checkOutput("reset_dut3", 1'b0, 5'b0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_dut5", 1'b1, 5'b0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        //      name          s5 rgb ent abt chen      flg       exp_mot  idx busy done err
        // Full three-channel run
        addVec("t1_arm",      0, 1, 0, 0, 5'b00111, 5'b00000, 5'b00000, 0, 0, 0, 0);
        addVec("t1_start",    0, 1, 1, 0, 5'b00111, 5'b00000, 5'b00100, 2, 1, 0, 0);
        addVec("t1_ch2_wait", 0, 1, 0, 0, 5'b00111, 5'b00000, 5'b00100, 2, 1, 0, 0);
        addVec("t1_ch2_flag", 0, 1, 0, 0, 5'b00111, 5'b00100, 5'b00010, 1, 1, 0, 0);
        addVec("t1_ch1_wait", 0, 1, 0, 0, 5'b00111, 5'b00000, 5'b00010, 1, 1, 0, 0);
        addVec("t1_ch1_flag", 0, 1, 0, 0, 5'b00111, 5'b00010, 5'b00001, 0, 1, 0, 0);
        addVec("t1_ch0_flag", 0, 1, 0, 0, 5'b00111, 5'b00001, 5'b00000, 0, 0, 1, 0);
        addVec("t1_idle",     0, 1, 0, 0, 5'b00111, 5'b00000, 5'b00000, 0, 0, 0, 0);
        addVec("t1_stay",     0, 0, 0, 0, 5'b00111, 5'b00000, 5'b00000, 0, 0, 0, 0);
        // Skip mask 101, then empty mask
        addVec("t2_arm",      0, 1, 0, 0, 5'b00101, 5'b00000, 5'b00000, 0, 0, 0, 0);
        addVec("t2_start",    0, 1, 1, 0, 5'b00101, 5'b00000, 5'b00100, 2, 1, 0, 0);
        addVec("t2_skip1",    0, 1, 0, 0, 5'b00101, 5'b00100, 5'b00001, 0, 1, 0, 0);
        addVec("t2_done",     0, 1, 0, 0, 5'b00101, 5'b00001, 5'b00000, 0, 0, 1, 0);
        addVec("t2_idle",     0, 0, 0, 0, 5'b00101, 5'b00000, 5'b00000, 0, 0, 0, 0);
        addVec("t2z_arm",     0, 1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0);
        addVec("t2z_done",    0, 1, 1, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 1, 0);
        addVec("t2z_idle",    0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0);
        // Abort while channel 1 is loading
        addVec("t3_arm",      0, 1, 0, 0, 5'b00111, 5'b00000, 5'b00000, 0, 0, 0, 0);
        addVec("t3_start",    0, 1, 1, 0, 5'b00111, 5'b00000, 5'b00100, 2, 1, 0, 0);
        addVec("t3_ch1",      0, 1, 0, 0, 5'b00111, 5'b00100, 5'b00010, 1, 1, 0, 0);
        addVec("t3_abort",    0, 1, 0, 1, 5'b00111, 5'b00000, 5'b00000, 1, 0, 0, 0);
        addVec("t3_idle",     0, 0, 0, 0, 5'b00111, 5'b00000, 5'b00000, 1, 0, 0, 0);
        // rgb_full drop, enter without colour, foreign flags, late ch_en change
        addVec("t5_arm",      0, 1, 0, 0, 5'b00111, 5'b00000, 5'b00000, 1, 0, 0, 0);
        addVec("t5_drop",     0, 0, 0, 0, 5'b00111, 5'b00000, 5'b00000, 1, 0, 0, 0);
        addVec("t5_ent_norgb",0, 0, 1, 0, 5'b00111, 5'b00000, 5'b00000, 1, 0, 0, 0);
        addVec("t5_rearm",    0, 1, 0, 0, 5'b00111, 5'b00000, 5'b00000, 1, 0, 0, 0);
        addVec("t5_start",    0, 1, 1, 0, 5'b00111, 5'b00000, 5'b00100, 2, 1, 0, 0);
        addVec("t5_flag0",    0, 1, 1, 0, 5'b00111, 5'b00001, 5'b00100, 2, 1, 0, 0);
        addVec("t5_flag01",   0, 1, 0, 0, 5'b00111, 5'b00011, 5'b00100, 2, 1, 0, 0);
        addVec("t5_flag2",    0, 1, 0, 0, 5'b00111, 5'b00100, 5'b00010, 1, 1, 0, 0);
        addVec("t5_chen_chg", 0, 1, 0, 0, 5'b00000, 5'b00010, 5'b00001, 0, 1, 0, 0);
        addVec("t5_done",     0, 1, 0, 0, 5'b00000, 5'b00001, 5'b00000, 0, 0, 1, 0);
        addVec("t5_idle",     0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0);
        // Five-channel instance, mask 10110
        addVec("t6_arm",      1, 1, 0, 0, 5'b10110, 5'b00000, 5'b00000, 0, 0, 0, 0);
        addVec("t6_start",    1, 1, 1, 0, 5'b10110, 5'b00000, 5'b10000, 4, 1, 0, 0);
        addVec("t6_ch4_flag", 1, 1, 0, 0, 5'b10110, 5'b10000, 5'b00100, 2, 1, 0, 0);
        addVec("t6_ch2_wait", 1, 1, 0, 0, 5'b10110, 5'b00000, 5'b00100, 2, 1, 0, 0);
        addVec("t6_ch2_flag", 1, 1, 0, 0, 5'b10110, 5'b00100, 5'b00010, 1, 1, 0, 0);
        addVec("t6_done",     1, 1, 0, 0, 5'b10110, 5'b00010, 5'b00000, 1, 0, 1, 0);
        addVec("t6_idle",     1, 0, 0, 0, 5'b10110, 5'b00000, 5'b00000, 1, 0, 0, 0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].sel5, vecs[k].rgb, vecs[k].ent, vecs[k].abt, vecs[k].chen, vecs[k].flg);
            step();
            checkOutput(vecs[k].name, vecs[k].sel5, vecs[k].exp_mot, vecs[k].exp_idx,
                        vecs[k].exp_busy, vecs[k].exp_done, vecs[k].exp_err);
        end

        // Reset asserted while channel 1 is loading
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("rst_armed", 1'b0, 5'b00000, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("rst_load", 1'b0, 5'b00100, 2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00100);
        step();
        checkOutput("rst_ch1", 1'b0, 5'b00010, 1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("rst_mid_load", 1'b0, 5'b00000, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("rst_hold_enter", 1'b0, 5'b00000, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("rst_release", 1'b0, 5'b00000, 0, 1'b0, 1'b0, 1'b0);

`ifdef WATCHDOG_EN
        // Channel 2 never flags: fault exactly 8 cycles after its motor starts
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("wd_start", 1'b0, 5'b00100, 2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        for (int i = 1; i <= 7; i++) begin
            step();
            checkOutput($sformatf("wd_wait%0d", i), 1'b0, 5'b00100, 2, 1'b1, 1'b0, 1'b0);
        end
        step();
        checkOutput("wd_fault", 1'b0, 5'b00000, 2, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("wd_fault_hold", 1'b0, 5'b00000, 2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("wd_ack", 1'b0, 5'b00000, 2, 1'b0, 1'b0, 1'b0);

        // Flag arriving on the expiry cycle wins over the fault
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'b00111, 5'b00000);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        for (int i = 1; i <= 7; i++) step();
        checkOutput("wd_pre_expiry", 1'b0, 5'b00100, 2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00100);
        step();
        checkOutput("wd_flag_wins", 1'b0, 5'b00010, 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("wd_ch1_fresh", 1'b0, 5'b00010, 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'b00111, 5'b00000);
        step();
        checkOutput("wd_abort", 1'b0, 5'b00000, 1, 1'b0, 1'b0, 1'b0);
`else
        // Without the watchdog a stalled channel simply keeps loading
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'b00111, 5'b00000);
        step();
        checkOutput("nowd_start", 1'b0, 5'b00100, 2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00000);
        for (int i = 0; i < 20; i++) step();
        checkOutput("nowd_no_fault", 1'b0, 5'b00100, 2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'b00111, 5'b00000);
        step();
        checkOutput("nowd_abort", 1'b0, 5'b00000, 2, 1'b0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
